// File: rtl/mux_serializer_pkg.sv
// Shared types and helpers for the masked bit serializer.
package mux_serializer_pkg;

  localparam int WORD_W = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [WORD_W-1:0] vec);
    lowest_set = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  function automatic logic [IDX_W-1:0] highest_set(input logic [WORD_W-1:0] vec);
    highest_set = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (vec[i]) highest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/mux_16to1.sv
// Plain 16:1 single-bit selector.
module mux_16to1 (
  input  logic [15:0] data_in,
  input  logic [3:0]  select,
  output logic        data_out
);

  assign data_out = data_in[select];

endmodule

// File: rtl/mux_serializer.sv
// Serializes the mask-enabled bits of a 16-bit word, one bit per transfer.
//
// state | meaning
// IDLE  | ready for a word; no output presented
// SHIFT | presenting latched_data[sel]; advances on each downstream transfer
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [WORD_W-1:0] in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              drop_pulse
);

  state_t              state;
  state_t              state_nxt;
  logic [WORD_W-1:0]   data_q;
  logic [WORD_W-1:0]   mask_q;
  logic [IDX_W-1:0]    sel;
  logic                drop_q;
  logic [WORD_W-1:0]   remain;
  logic [IDX_W-1:0]    first_idx;
  logic [IDX_W-1:0]    next_idx;
  logic                last;
  logic                accept;
  logic                xfer;
  logic                mux_bit;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  // Enabled bits still ahead of sel in emission order; the walk never wraps.
  always_comb begin
    remain = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (LSB_FIRST) remain[i] = mask_q[i] & (IDX_W'(i) > sel);
      else           remain[i] = mask_q[i] & (IDX_W'(i) < sel);
    end
  end

  assign last      = ~|remain;
  assign next_idx  = LSB_FIRST ? lowest_set(remain)  : highest_set(remain);
  assign first_idx = LSB_FIRST ? lowest_set(in_mask) : highest_set(in_mask);

  mux_16to1 u_mux (
    .data_in  (data_q),
    .select   (sel),
    .data_out (mux_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && |in_mask) state_nxt = SHIFT;
      SHIFT:   if (xfer && last)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_bit    = 1'b0;
    out_idx    = '0;
    out_last   = 1'b0;
    drop_pulse = drop_q;
    case (state)
      IDLE: in_ready = 1'b1;
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_bit   = mux_bit;
        out_idx   = sel;
        out_last  = last;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
      sel    <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= accept & ~|in_mask;
      if (accept) begin
        data_q <= in_data;
        mask_q <= in_mask;
        sel    <= first_idx;
      end else if (xfer && !last) begin
        sel <= next_idx;
      end
    end
  end

endmodule
